// File: rtl/c_tile_pkg.sv
// Shared C-tile definitions: default tile geometry, reader FSM states and the element record
// carried from the C SRAM read port to the output stream.
package c_tile_pkg;

   localparam int unsigned C_M      = 8;
   localparam int unsigned C_N      = 8;
   localparam int unsigned C_DATA_W = 32;
   localparam int unsigned C_ROW_W  = (C_M <= 1) ? 1 : $clog2(C_M);
   localparam int unsigned C_COL_W  = (C_N <= 1) ? 1 : $clog2(C_N);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } rd_state_e;

   typedef struct packed {
      logic [C_DATA_W-1:0] data;
      logic [C_ROW_W-1:0]  row;
      logic [C_COL_W-1:0]  col;
      logic                last;
   } c_elem_t;

endpackage

// File: rtl/c_tile_rd_fifo2.sv
// Two-entry synchronous FIFO holding returned C elements; clear empties it and wins over push.
module c_tile_rd_fifo2
   import c_tile_pkg::*;
#(
   parameter type elem_t = c_elem_t
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  elem_t      push_elem_i,
   input  logic       pop_i,
   input  logic       clear_i,
   output logic [1:0] count_o,
   output elem_t      head_o
);

   elem_t      mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic       do_push;
   logic       do_pop;

   always_comb begin
      do_push = push_i && (count_q != 2'd2 || pop_i);
      do_pop  = pop_i && (count_q != 2'd0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_elem_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/c_tile_reader_stream.sv
// Drains a finished MxN C tile from the C SRAM in row-major order onto a valid/ready stream,
// absorbing the 1-cycle SRAM read latency and downstream backpressure.
module c_tile_reader_stream
   import c_tile_pkg::*;
#(
   parameter int unsigned M      = C_M,
   parameter int unsigned N      = C_N,
   parameter int unsigned DATA_W = C_DATA_W,
   parameter int unsigned ROW_W  = (M <= 1) ? 1 : $clog2(M),
   parameter int unsigned COL_W  = (N <= 1) ? 1 : $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              c_re,
   output logic [ROW_W-1:0]  c_rrow,
   output logic [COL_W-1:0]  c_rcol,
   input  logic [DATA_W-1:0] c_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ROW_W-1:0]  out_row,
   output logic [COL_W-1:0]  out_col,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
      logic              last;
   } elem_t;

   rd_state_e        state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic             inflight_q;
   logic [ROW_W-1:0] ifl_row_q;
   logic [COL_W-1:0] ifl_col_q;
   logic             ifl_last_q;

   logic [1:0]       fifo_count;
   elem_t            head;
   elem_t            push_elem;
   logic             pop;
   logic             at_last;
   logic [2:0]       credit_used;

   always_comb begin
      at_last   = (row_q == ROW_W'(M - 1)) && (col_q == COL_W'(N - 1));
      out_valid = (fifo_count != 2'd0);
      pop       = out_valid && out_ready;
      // A head leaving this cycle frees its slot before the next return arrives,
      // which is what keeps one element per cycle flowing with only two entries.
      credit_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      c_re    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               row_d   = '0;
               col_d   = '0;
            end
         end
         RUN: begin
            if (credit_used < 3'd2) begin
               c_re = 1'b1;
               if (at_last) begin
                  state_d = DRAIN;
               end else if (col_q == COL_W'(N - 1)) begin
                  col_d = '0;
                  row_d = row_q + ROW_W'(1);
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         DRAIN: begin
            if (pop && head.last) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d = IDLE;
         row_d   = row_q;
         col_d   = col_q;
         c_re    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         inflight_q <= 1'b0;
         ifl_row_q  <= '0;
         ifl_col_q  <= '0;
         ifl_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         inflight_q <= c_re;
         if (c_re) begin
            ifl_row_q  <= row_q;
            ifl_col_q  <= col_q;
            ifl_last_q <= at_last;
         end
      end
   end

   always_comb begin
      push_elem.data = c_rdata;
      push_elem.row  = ifl_row_q;
      push_elem.col  = ifl_col_q;
      push_elem.last = ifl_last_q;
   end

   c_tile_rd_fifo2 #(
      .elem_t (elem_t)
   ) u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (inflight_q),
      .push_elem_i (push_elem),
      .pop_i       (pop),
      .clear_i     (abort),
      .count_o     (fifo_count),
      .head_o      (head)
   );

   assign c_rrow   = row_q;
   assign c_rcol   = col_q;
   assign out_data = head.data;
   assign out_row  = head.row;
   assign out_col  = head.col;
   assign out_last = head.last;
   assign busy     = (state_q == RUN) || (state_q == DRAIN);
   assign done     = (state_q == DONE);

endmodule
